// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipelined RV32I control unit carrying the control word from Decode through Writeback
module pipe_ctrl #(
  parameter bit EXT_BRANCH = 1'b1,
  parameter bit EXT_SHIFT = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr_d,
  input  logic        stall,
  input  logic        zero_e,
  input  logic        lt_e,
  input  logic        ltu_e,
  output logic [2:0]  imm_src_d,
  output logic [3:0]  alu_ctrl_e,
  output logic        alu_src_e,
  output logic        alu_a_pc_e,
  output logic        jalr_e,
  output logic        pc_src_e,
  output logic        flush_d,
  output logic        illegal_e,
  output logic        result_src_e,
  output logic        mem_write_m,
  output logic [2:0]  funct3_m,
  output logic        reg_write_m,
  output logic        reg_write_w,
  output logic [1:0]  result_src_w
);
  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       jalr;
    logic [3:0] alu_ctrl;
    logic       alu_src;
    logic       alu_a_pc;
    logic [2:0] funct3;
    logic       illegal;
  } ctrl_t;

  localparam ctrl_t ILL_WORD = '{illegal: 1'b1, default: '0};

  logic [6:0] op;
  logic [2:0] f3;
  logic       f7b5;
  logic       f7_ok;
  logic       shift;
  logic       ill;
  logic       cond;
  logic [1:0] result_src_m;
  logic       unused_bits;
  ctrl_t      dec;
  ctrl_t      nxt;
  ctrl_t      ex;

  function automatic logic [3:0] alu_op(input logic [2:0] f, input logic alt);
    return f == 3'd0 ? {3'd0, alt} : f == 3'd1 ? 4'd7 : f == 3'd2 ? 4'd5 : f == 3'd3 ? 4'd6 :
           f == 3'd4 ? 4'd4 : f == 3'd5 ? (alt ? 4'd9 : 4'd8) : f == 3'd6 ? 4'd3 : 4'd2;
  endfunction

  assign op = instr_d[6:0];
  assign f3 = instr_d[14:12];
  assign f7b5 = instr_d[30];
  assign f7_ok = instr_d[31:25] == 7'h00 || instr_d[31:25] == 7'h20;
  assign shift = f3[1:0] == 2'b01;
  assign unused_bits = ^{instr_d[24:15], instr_d[11:7]};

  // decode the instruction in Decode into a control word and immediate type
  always_comb begin
    dec = '0;
    dec.funct3 = f3;
    imm_src_d = 3'b000;
    ill = 1'b0;
    case (op)
      7'b0110011: begin
        dec.reg_write = 1'b1;
        dec.alu_ctrl = alu_op(f3, f7b5);
        ill = !f7_ok || (shift && !EXT_SHIFT);
      end
      7'b0010011: begin
        dec.reg_write = 1'b1;
        dec.alu_src = 1'b1;
        dec.alu_ctrl = alu_op(f3, f3 == 3'b101 && f7b5);
        ill = shift && !EXT_SHIFT;
      end
      7'b0000011: begin
        dec.reg_write = 1'b1;
        dec.alu_src = 1'b1;
        dec.result_src = 2'b01;
      end
      7'b0100011: begin
        dec.mem_write = 1'b1;
        dec.alu_src = 1'b1;
        imm_src_d = 3'b001;
      end
      7'b1100011: begin
        dec.branch = 1'b1;
        dec.alu_ctrl = 4'd1;
        imm_src_d = 3'b010;
        ill = f3[2:1] == 2'b01 || (f3[2] && !EXT_BRANCH);
      end
      7'b1101111: begin
        dec.reg_write = 1'b1;
        dec.jump = 1'b1;
        dec.alu_src = 1'b1;
        dec.alu_a_pc = 1'b1;
        dec.result_src = 2'b10;
        imm_src_d = 3'b100;
      end
      7'b1100111: begin
        dec.reg_write = 1'b1;
        dec.jump = 1'b1;
        dec.jalr = 1'b1;
        dec.alu_src = 1'b1;
        dec.result_src = 2'b10;
      end
      7'b0110111: begin
        dec.reg_write = 1'b1;
        dec.alu_src = 1'b1;
        dec.alu_ctrl = 4'd15;
        imm_src_d = 3'b011;
      end
      7'b0010111: begin
        dec.reg_write = 1'b1;
        dec.alu_src = 1'b1;
        dec.alu_a_pc = 1'b1;
        imm_src_d = 3'b011;
      end
      default: ill = 1'b1;
    endcase
  end

  // next ID/EX word: a wrong-path flush or stall injects a plain bubble, illegal decodes a flagged bubble
  always_comb begin
    nxt = (flush_d || stall) ? '0 : ill ? ILL_WORD : dec;
  end

  assign cond = ex.funct3[2:1] == 2'b01 ? 1'b0 :
                ((ex.funct3[2] ? (ex.funct3[1] ? ltu_e : lt_e) : zero_e) ^ ex.funct3[0]);
  assign pc_src_e = ex.jump | (ex.branch & cond);
  assign flush_d = pc_src_e;
  assign alu_ctrl_e = ex.alu_ctrl;
  assign alu_src_e = ex.alu_src;
  assign alu_a_pc_e = ex.alu_a_pc;
  assign jalr_e = ex.jalr;
  assign illegal_e = ex.illegal;
  assign result_src_e = ex.result_src[0];

  // pipeline registers; EX/MEM and MEM/WB advance every cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex <= '0;
      reg_write_m <= 1'b0;
      result_src_m <= 2'b00;
      mem_write_m <= 1'b0;
      funct3_m <= 3'b000;
      reg_write_w <= 1'b0;
      result_src_w <= 2'b00;
    end else begin
      ex <= nxt;
      reg_write_m <= ex.reg_write;
      result_src_m <= ex.result_src;
      mem_write_m <= ex.mem_write;
      funct3_m <= ex.funct3;
      reg_write_w <= reg_write_m;
      result_src_w <= result_src_m;
    end
  end
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed and random checking of pipe_ctrl (all extensions vs none) against a mnemonic-level model
module tb_pipe_ctrl;
  typedef struct packed {
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       fix3;
    logic       fix7;
    logic [1:0] ext;
    logic       rw;
    logic [1:0] rs;
    logic       mw;
    logic       br;
    logic       jp;
    logic       jr;
    logic [3:0] alu;
    logic       src;
    logic       apc;
    logic [2:0] imm;
    logic       ill;
  } ent_t;

  typedef struct packed {
    logic       rw;
    logic [1:0] rs;
    logic       mw;
    logic       br;
    logic       jp;
    logic       jr;
    logic [3:0] alu;
    logic       src;
    logic       apc;
    logic [2:0] f3;
    logic       ill;
    logic       chk3;
  } cw_t;

  localparam logic [31:0] ADD = 32'h002081B3;
  localparam logic [31:0] BEQ = 32'h00208463;
  localparam logic [31:0] BLT = 32'h0020C463;
  localparam logic [31:0] LW = 32'h0000A283;
  localparam logic [31:0] JALR = 32'h000280E7;
  localparam logic [31:0] JAL = 32'h000000EF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] instr_d = 32'h0;
  logic stall = 1'b0;
  logic zero_e = 1'b0;
  logic lt_e = 1'b0;
  logic ltu_e = 1'b0;
  logic [1:0][2:0] imm_src_d;
  logic [1:0][3:0] alu_ctrl_e;
  logic [1:0] alu_src_e, alu_a_pc_e, jalr_e, pc_src_e, flush_d, illegal_e, result_src_e;
  logic [1:0] mem_write_m, reg_write_m, reg_write_w;
  logic [1:0][2:0] funct3_m;
  logic [1:0][1:0] result_src_w;

  cw_t ex[2];
  cw_t mm[2];
  cw_t wb[2];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.EXT_BRANCH(1'b1), .EXT_SHIFT(1'b1)) dut_full (
    .clk(clk), .rst_n(rst_n), .instr_d(instr_d), .stall(stall),
    .zero_e(zero_e), .lt_e(lt_e), .ltu_e(ltu_e),
    .imm_src_d(imm_src_d[0]), .alu_ctrl_e(alu_ctrl_e[0]), .alu_src_e(alu_src_e[0]),
    .alu_a_pc_e(alu_a_pc_e[0]), .jalr_e(jalr_e[0]), .pc_src_e(pc_src_e[0]), .flush_d(flush_d[0]),
    .illegal_e(illegal_e[0]), .result_src_e(result_src_e[0]), .mem_write_m(mem_write_m[0]),
    .funct3_m(funct3_m[0]), .reg_write_m(reg_write_m[0]), .reg_write_w(reg_write_w[0]),
    .result_src_w(result_src_w[0])
  );

  pipe_ctrl #(.EXT_BRANCH(1'b0), .EXT_SHIFT(1'b0)) dut_base (
    .clk(clk), .rst_n(rst_n), .instr_d(instr_d), .stall(stall),
    .zero_e(zero_e), .lt_e(lt_e), .ltu_e(ltu_e),
    .imm_src_d(imm_src_d[1]), .alu_ctrl_e(alu_ctrl_e[1]), .alu_src_e(alu_src_e[1]),
    .alu_a_pc_e(alu_a_pc_e[1]), .jalr_e(jalr_e[1]), .pc_src_e(pc_src_e[1]), .flush_d(flush_d[1]),
    .illegal_e(illegal_e[1]), .result_src_e(result_src_e[1]), .mem_write_m(mem_write_m[1]),
    .funct3_m(funct3_m[1]), .reg_write_m(reg_write_m[1]), .reg_write_w(reg_write_w[1]),
    .result_src_w(result_src_w[1])
  );

  function automatic ent_t e(logic [6:0] op, logic [2:0] f3, logic [6:0] f7, logic fix3, logic fix7,
                             logic [1:0] ext, logic rw, logic [1:0] rs, logic mw, logic br, logic jp,
                             logic jr, logic [3:0] alu, logic src, logic apc, logic [2:0] imm, logic ill);
    return '{op, f3, f7, fix3, fix7, ext, rw, rs, mw, br, jp, jr, alu, src, apc, imm, ill};
  endfunction

  // mnemonic table: encoding fields, extension (1 branch, 2 shift), expected controls; imm 7 = not checked
  function automatic ent_t tbl(int m);
    case (m)
      0:  return e(7'h33, 3'd0, 7'h00, 1, 1, 0, 1, 0, 0, 0, 0, 0, 4'd0, 0, 0, 7, 0);
      1:  return e(7'h33, 3'd0, 7'h20, 1, 1, 0, 1, 0, 0, 0, 0, 0, 4'd1, 0, 0, 7, 0);
      2:  return e(7'h33, 3'd1, 7'h00, 1, 1, 2, 1, 0, 0, 0, 0, 0, 4'd7, 0, 0, 7, 0);
      3:  return e(7'h33, 3'd2, 7'h00, 1, 1, 0, 1, 0, 0, 0, 0, 0, 4'd5, 0, 0, 7, 0);
      4:  return e(7'h33, 3'd3, 7'h00, 1, 1, 0, 1, 0, 0, 0, 0, 0, 4'd6, 0, 0, 7, 0);
      5:  return e(7'h33, 3'd4, 7'h00, 1, 1, 0, 1, 0, 0, 0, 0, 0, 4'd4, 0, 0, 7, 0);
      6:  return e(7'h33, 3'd5, 7'h00, 1, 1, 2, 1, 0, 0, 0, 0, 0, 4'd8, 0, 0, 7, 0);
      7:  return e(7'h33, 3'd5, 7'h20, 1, 1, 2, 1, 0, 0, 0, 0, 0, 4'd9, 0, 0, 7, 0);
      8:  return e(7'h33, 3'd6, 7'h00, 1, 1, 0, 1, 0, 0, 0, 0, 0, 4'd3, 0, 0, 7, 0);
      9:  return e(7'h33, 3'd7, 7'h00, 1, 1, 0, 1, 0, 0, 0, 0, 0, 4'd2, 0, 0, 7, 0);
      10: return e(7'h13, 3'd0, 7'h00, 1, 0, 0, 1, 0, 0, 0, 0, 0, 4'd0, 1, 0, 0, 0);
      11: return e(7'h13, 3'd2, 7'h00, 1, 0, 0, 1, 0, 0, 0, 0, 0, 4'd5, 1, 0, 0, 0);
      12: return e(7'h13, 3'd3, 7'h00, 1, 0, 0, 1, 0, 0, 0, 0, 0, 4'd6, 1, 0, 0, 0);
      13: return e(7'h13, 3'd4, 7'h00, 1, 0, 0, 1, 0, 0, 0, 0, 0, 4'd4, 1, 0, 0, 0);
      14: return e(7'h13, 3'd6, 7'h00, 1, 0, 0, 1, 0, 0, 0, 0, 0, 4'd3, 1, 0, 0, 0);
      15: return e(7'h13, 3'd7, 7'h00, 1, 0, 0, 1, 0, 0, 0, 0, 0, 4'd2, 1, 0, 0, 0);
      16: return e(7'h13, 3'd1, 7'h00, 1, 1, 2, 1, 0, 0, 0, 0, 0, 4'd7, 1, 0, 0, 0);
      17: return e(7'h13, 3'd5, 7'h00, 1, 1, 2, 1, 0, 0, 0, 0, 0, 4'd8, 1, 0, 0, 0);
      18: return e(7'h13, 3'd5, 7'h20, 1, 1, 2, 1, 0, 0, 0, 0, 0, 4'd9, 1, 0, 0, 0);
      19: return e(7'h03, 3'd2, 7'h00, 1, 0, 0, 1, 1, 0, 0, 0, 0, 4'd0, 1, 0, 0, 0);
      20: return e(7'h03, 3'd4, 7'h00, 1, 0, 0, 1, 1, 0, 0, 0, 0, 4'd0, 1, 0, 0, 0);
      21: return e(7'h23, 3'd2, 7'h00, 1, 0, 0, 0, 0, 1, 0, 0, 0, 4'd0, 1, 0, 1, 0);
      22: return e(7'h23, 3'd0, 7'h00, 1, 0, 0, 0, 0, 1, 0, 0, 0, 4'd0, 1, 0, 1, 0);
      23: return e(7'h63, 3'd0, 7'h00, 1, 0, 0, 0, 0, 0, 1, 0, 0, 4'd1, 0, 0, 2, 0);
      24: return e(7'h63, 3'd1, 7'h00, 1, 0, 0, 0, 0, 0, 1, 0, 0, 4'd1, 0, 0, 2, 0);
      25: return e(7'h63, 3'd4, 7'h00, 1, 0, 1, 0, 0, 0, 1, 0, 0, 4'd1, 0, 0, 2, 0);
      26: return e(7'h63, 3'd5, 7'h00, 1, 0, 1, 0, 0, 0, 1, 0, 0, 4'd1, 0, 0, 2, 0);
      27: return e(7'h63, 3'd6, 7'h00, 1, 0, 1, 0, 0, 0, 1, 0, 0, 4'd1, 0, 0, 2, 0);
      28: return e(7'h63, 3'd7, 7'h00, 1, 0, 1, 0, 0, 0, 1, 0, 0, 4'd1, 0, 0, 2, 0);
      29: return e(7'h6f, 3'd0, 7'h00, 0, 0, 0, 1, 2, 0, 0, 1, 0, 4'd0, 1, 1, 4, 0);
      30: return e(7'h67, 3'd0, 7'h00, 1, 0, 0, 1, 2, 0, 0, 1, 1, 4'd0, 1, 0, 0, 0);
      31: return e(7'h37, 3'd0, 7'h00, 0, 0, 0, 1, 0, 0, 0, 0, 0, 4'd15, 1, 0, 3, 0);
      32: return e(7'h17, 3'd0, 7'h00, 0, 0, 0, 1, 0, 0, 0, 0, 0, 4'd0, 1, 1, 3, 0);
      34: return e(7'h33, 3'd0, 7'h01, 0, 1, 0, 0, 0, 0, 0, 0, 0, 4'd0, 0, 0, 7, 1);
      35: return e(7'h63, 3'd2, 7'h00, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0, 0, 0, 7, 1);
      36: return e(7'h63, 3'd3, 7'h00, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0, 0, 0, 7, 1);
      default: return e(7'h00, 3'd0, 7'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0, 0, 0, 7, 1);
    endcase
  endfunction

  function automatic logic known_op(logic [6:0] o);
    return o inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6f, 7'h67, 7'h37, 7'h17};
  endfunction

  function automatic logic [31:0] build(int m);
    ent_t t = tbl(m);
    logic [31:0] w = $urandom;
    logic [6:0] o = 7'h00;
    w[6:0] = t.op;
    if (t.fix3) w[14:12] = t.f3;
    if (t.fix7) w[31:25] = t.f7;
    if (m == 33) begin
      for (int k = 0; k < 64 && known_op(o); k++) o = 7'($urandom);
      w[6:0] = known_op(o) ? 7'h7f : o;
    end
    return w;
  endfunction

  // expected control word for variant v (0 all extensions, 1 none)
  function automatic cw_t expect_word(int m, logic [31:0] i, int v);
    ent_t t = tbl(m);
    cw_t c = '0;
    if (t.ill || (v == 1 && t.ext != 0)) begin
      c.ill = 1'b1;
      return c;
    end
    c.rw = t.rw;
    c.rs = t.rs;
    c.mw = t.mw;
    c.br = t.br;
    c.jp = t.jp;
    c.jr = t.jr;
    c.alu = t.alu;
    c.src = t.src;
    c.apc = t.apc;
    c.f3 = i[14:12];
    c.chk3 = t.mw || t.rs == 2'b01;
    return c;
  endfunction

  function automatic logic pc_exp(int v);
    logic c;
    case (ex[v].f3)
      3'd0: c = zero_e;
      3'd1: c = !zero_e;
      3'd4: c = lt_e;
      3'd5: c = !lt_e;
      3'd6: c = ltu_e;
      3'd7: c = !ltu_e;
      default: c = 1'b0;
    endcase
    return ex[v].jp || (ex[v].br && c);
  endfunction

  task automatic chk(string tag, int v, logic [31:0] o, logic [31:0] x);
    checks++;
    assert (o === x) else begin
      failures++;
      $error("FAIL %s v%0d observed=%0h expected=%0h", tag, v, o, x);
    end
  endtask

  task automatic check_all(int m);
    ent_t t = tbl(m);
    logic p;
    for (int v = 0; v < 2; v++) begin
      p = pc_exp(v);
      if (t.imm != 3'd7) chk("imm_src_d", v, 32'(imm_src_d[v]), 32'(t.imm));
      chk("alu_ctrl_e", v, 32'(alu_ctrl_e[v]), 32'(ex[v].alu));
      chk("alu_src_e", v, 32'(alu_src_e[v]), 32'(ex[v].src));
      chk("alu_a_pc_e", v, 32'(alu_a_pc_e[v]), 32'(ex[v].apc));
      chk("jalr_e", v, 32'(jalr_e[v]), 32'(ex[v].jr));
      chk("pc_src_e", v, 32'(pc_src_e[v]), 32'(p));
      chk("flush_d", v, 32'(flush_d[v]), 32'(p));
      chk("illegal_e", v, 32'(illegal_e[v]), 32'(ex[v].ill));
      chk("result_src_e", v, 32'(result_src_e[v]), 32'(ex[v].rs[0]));
      chk("mem_write_m", v, 32'(mem_write_m[v]), 32'(mm[v].mw));
      if (mm[v].chk3) chk("funct3_m", v, 32'(funct3_m[v]), 32'(mm[v].f3));
      chk("reg_write_m", v, 32'(reg_write_m[v]), 32'(mm[v].rw));
      chk("reg_write_w", v, 32'(reg_write_w[v]), 32'(wb[v].rw));
      chk("result_src_w", v, 32'(result_src_w[v]), 32'(wb[v].rs));
    end
  endtask

  // one cycle: drive at posedge+1, check mid-cycle, then advance the model across the edge
  task automatic cyc(logic [31:0] i, int m, bit s, bit z, bit l, bit lu);
    logic p;
    instr_d = i;
    stall = s;
    zero_e = z;
    lt_e = l;
    ltu_e = lu;
    #4;
    check_all(m);
    @(posedge clk);
    if (rst_n) begin
      for (int v = 0; v < 2; v++) begin
        p = pc_exp(v);
        wb[v] = mm[v];
        mm[v] = ex[v];
        ex[v] = (p || s) ? cw_t'('0) : expect_word(m, i, v);
      end
    end
    #1;
  endtask

  task automatic reset_model();
    for (int v = 0; v < 2; v++) begin
      ex[v] = '0;
      mm[v] = '0;
      wb[v] = '0;
    end
  endtask

  initial begin
    int m;
    reset_model();
    #3;
    check_all(33);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(ADD, 0, 0, 0, 0, 0);
    cyc(ADD, 0, 0, 0, 0, 0);
    cyc(ADD, 0, 0, 0, 0, 0);
    cyc(ADD, 0, 0, 0, 0, 0);
    cyc(BEQ, 23, 0, 0, 0, 0);
    cyc(ADD, 0, 0, 1, 0, 0);
    cyc(ADD, 0, 0, 0, 0, 0);
    cyc(BEQ, 23, 0, 1, 0, 0);
    cyc(ADD, 0, 0, 0, 0, 0);
    cyc(ADD, 0, 0, 0, 0, 0);
    cyc(BLT, 25, 0, 0, 0, 0);
    cyc(ADD, 0, 0, 0, 1, 0);
    cyc(ADD, 0, 0, 0, 0, 0);
    cyc(ADD, 0, 0, 0, 0, 0);
    cyc(ADD, 0, 0, 0, 0, 0);
    cyc(LW, 19, 0, 0, 0, 0);
    cyc(ADD, 0, 1, 0, 0, 0);
    cyc(ADD, 0, 0, 0, 0, 0);
    cyc(ADD, 0, 0, 0, 0, 0);
    cyc(JALR, 30, 0, 0, 0, 0);
    cyc(ADD, 0, 0, 0, 0, 0);
    cyc(ADD, 0, 0, 0, 0, 0);
    cyc(ADD, 0, 0, 0, 0, 0);
    cyc(BEQ, 23, 0, 0, 0, 0);
    cyc(ADD, 0, 1, 1, 0, 0);
    cyc(ADD, 0, 0, 0, 0, 0);
    cyc(ADD, 0, 0, 0, 0, 0);
    cyc(ADD, 0, 0, 0, 0, 0);
    cyc(JAL, 29, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    reset_model();
    check_all(29);
    repeat (3) cyc(ADD, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    repeat (4) cyc(ADD, 0, 0, 0, 0, 0);
    for (int n = 0; n < 800; n++) begin
      m = $urandom_range(0, 36);
      cyc(build(m), m, $urandom_range(0, 4) == 0, 1'($urandom), 1'($urandom), 1'($urandom));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipelined successor to the single-cycle control unit. Decodes the Decode-stage instruction, carries the control word through the ID/EX, EX/MEM and MEM/WB registers, and resolves all six RV32I conditional branches in Execute from ALU flags. It also handles hazard-unit stalls and issues a wrong-path flush when a branch or jump is taken. It sits beside the datapath pipeline registers and drives every stage's controls.

## Interface
- EXT_BRANCH, 1, when 1 enables blt/bge/bltu/bgeu; when 0 those decode as illegal.
- EXT_SHIFT, 1, when 1 enables sll/srl/sra/slli/srli/srai; when 0 those decode as illegal.
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- instr_d  in  32  instruction in Decode.
- stall  in  1  hazard-unit stall: inject a bubble into Execute this edge.
- zero_e, lt_e, ltu_e  in  1 each  ALU flags from Execute: result==0, signed A<B, unsigned A<B.
- imm_src_d  out  3  immediate type, combinational from instr_d: 000 I, 001 S, 010 B, 011 U, 100 J.
- alu_ctrl_e  out  4  ALU op: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 slt, 6 sltu, 7 sll, 8 srl, 9 sra, 15 pass B.
- alu_src_e  out  1  ALU B operand: 1 immediate, 0 rs2.
- alu_a_pc_e  out  1  ALU A operand is PC (auipc, jal).
- jalr_e  out  1  next PC comes from ALU result.
- pc_src_e  out  1  redirect PC: taken branch, jal or jalr.
- flush_d  out  1  kill IF/ID; equals pc_src_e.
- illegal_e  out  1  instruction now in Execute was illegal.
- result_src_e  out  1  bit 0 of Execute's result_src, used by the hazard unit for load-use detection.
- mem_write_m  out  1  store enable in Memory.
- funct3_m  out  3  access size and sign for load/store.
- reg_write_m  out  1  Memory-stage writeback enable, used for forwarding.
- reg_write_w  out  1  register-file write enable.
- result_src_w  out  2  writeback source: 00 ALU, 01 memory, 10 PC+4.

## Operation
- **Decode (combinational on instr_d)**
  - Opcodes: 0110011 R, 0010011 I-ALU, 0000011 load, 0100011 store, 1100011 branch, 1101111 jal, 1100111 jalr, 0110111 lui, 0010111 auipc.
  - R-type ALU op comes from funct3 plus funct7[5]. I-ALU ignores funct7[5] except on srai.
  - Loads and stores use add with alu_src=1.
  - Branches use sub with alu_src=0.
  - lui uses pass B with alu_src=1.
  - auipc and jal use add with alu_a_pc=1 and alu_src=1.
  - jalr uses add with alu_src=1.
  - jal and jalr set result_src=10.
- **Illegal encodings:** unknown opcode; R-type funct7 not 0000000/0100000; branch funct3 010/011; disabled extensions.
  - An illegal instruction latches as a bubble with illegal_e=1.
- **Bubble:** reg_write, mem_write, branch, jump and jalr are all 0; illegal=0; other fields are don't-care, driven 0.
- **ID/EX register:**
  - If flush_d or stall, load a bubble; otherwise load the decoded word. Flush takes priority over stall.
- **EX/MEM and MEM/WB registers:** always advance and never stall.
- **pc_src_e** = jump_e OR (branch_e AND cond). cond is selected by funct3_e:
  - 000 zero_e
  - 001 !zero_e
  - 100 lt_e
  - 101 !lt_e
  - 110 ltu_e
  - 111 !ltu_e
- **Reset:** every pipeline register becomes a bubble. imm_src_d keeps following instr_d.

## Timing
- **Latency:** an instruction in Decode at cycle n drives:
  - *_e in cycle n+1
  - *_m in cycle n+2
  - *_w in cycle n+3
- pc_src_e and flush_d are combinational in cycle n+1. The flush takes effect at the n+1→n+2 edge.
  - The wrong-path instruction then in Decode becomes a bubble in Execute at n+2.
- stall held for k cycles gives k consecutive bubbles in Execute. Older instructions drain unaffected.
- **Simultaneous stall and flush:** a single bubble; no decoded instruction enters Execute.
- **rst_n low:** all outputs except imm_src_d go to 0 immediately, without waiting for a clock edge.
  - The first valid decode latches at the first rising edge after rst_n rises.
- Back-to-back taken branches are impossible: the second is always flushed.

## Test plan
- **Reset mid-stream:** rst_n=0 for 3 cycles while adds flow -> reg_write_w, mem_write_m, pc_src_e and illegal_e are 0 asynchronously. After release, the next add appears at *_e one cycle later.
- **R-type add:** 0x002081B3 (add x3,x1,x2) -> at n+1 alu_ctrl_e=0, alu_src_e=0. At n+3 reg_write_w=1, result_src_w=00.
- **beq taken:** 0x00208463 with zero_e=1 -> pc_src_e=1 and flush_d=1 at n+1. Execute holds a bubble at n+2. With zero_e=0 -> pc_src_e=0.
- **blt with EXT_BRANCH=1:** 0x0020C463 with lt_e=1 -> pc_src_e=1.
- **blt with EXT_BRANCH=0:** same instruction -> illegal_e=1, pc_src_e=0, reg_write stays 0 through WB.
- **Load-use stall:** 0x0000A283 (lw x5,0(x1)) then stall=1 for 1 cycle -> result_src_e=1 at n+1, a bubble in Execute at n+2, result_src_w=01 and reg_write_w=1 at n+3.
- **jalr:** 0x000280E7 -> jalr_e=1, pc_src_e=1, alu_src_e=1 at n+1. result_src_w=10 at n+3.
- **Stall and flush together:** assert stall in the same cycle pc_src_e=1 -> exactly one bubble, no duplicated instruction.
